// File: rtl/arm7_pkg.sv
// arm7_pkg: shared issue-stage types and ARM condition-code constants.
// Contents:
//   state_t    - issue FSM encoding (IDLE, BR_RUN, BR_GAP, ALU_WAIT)
//   CC_*       - instr[31:28] condition-code values EQ..NV
//   is_branch  - true for the B/BL class (instr[27:25] == 3'b101)
package arm7_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_RUN   = 2'd1,
        BR_GAP   = 2'd2,
        ALU_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    function automatic logic is_branch(input logic [31:0] i);
        return i[27:25] == 3'b101;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code check.
// Ports:
//   cond [3:0] - condition field instr[31:28]
//   nzcv [3:0] - CPSR flags {N,Z,C,V}
//   pass       - 1 when the instruction should take effect
module cond_eval
    import arm7_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = n == v;
            CC_LT:   pass = n != v;
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_issue.sv
// instr_issue: accepts one ARM instruction at a time and issues it either to
// the branch unit (fixed-length br_en pulse + one gap cycle) or to the ALU
// (valid/ready handshake, abortable by flush).
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   instr_valid, instr, instr_ready - fetch side handshake
//   flags_nzcv                      - CPSR flags sampled at acceptance
//   flush                           - aborts a pending ALU issue
//   br_en, br_cond, br_link,
//   br_offset                       - branch unit drive
//   alu_valid, alu_instr, alu_cond,
//   alu_ready                       - ALU issue handshake
//   busy                            - state is not IDLE
module instr_issue
    import arm7_pkg::*;
#(
    parameter int unsigned BR_HOLD_SHORT = 5,
    parameter int unsigned BR_HOLD_LINK  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [3:0]  flags_nzcv,
    input  logic        flush,
    output logic        br_en,
    output logic        br_cond,
    output logic        br_link,
    output logic [23:0] br_offset,
    output logic        alu_valid,
    output logic [31:0] alu_instr,
    output logic        alu_cond,
    input  logic        alu_ready,
    output logic        busy
);

    // Counter is loaded with hold-1 so BR_RUN lasts exactly hold cycles.
    localparam logic [3:0] HOLD_S = 4'(BR_HOLD_SHORT - 1);
    localparam logic [3:0] HOLD_L = 4'(BR_HOLD_LINK - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       pass;
    logic       accept;
    logic       branch;

    cond_eval u_cond_eval (
        .cond (instr[31:28]),
        .nzcv (flags_nzcv),
        .pass (pass)
    );

    assign accept = (state == IDLE) && instr_valid;
    assign branch = is_branch(instr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = instr_valid ? (branch ? BR_RUN : ALU_WAIT) : IDLE;
            BR_RUN:   state_nxt = (cnt == 4'd0) ? BR_GAP : BR_RUN;
            BR_GAP:   state_nxt = IDLE;
            ALU_WAIT: state_nxt = (flush || alu_ready) ? IDLE : ALU_WAIT;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = state == IDLE;
        br_en       = state == BR_RUN;
        alu_valid   = state == ALU_WAIT;
        busy        = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            br_cond   <= 1'b0;
            br_link   <= 1'b0;
            br_offset <= '0;
            alu_instr <= '0;
            alu_cond  <= 1'b0;
        end else if (accept && branch) begin
            // Only a taken link branch gets the long hold.
            cnt       <= (pass && instr[24]) ? HOLD_L : HOLD_S;
            br_cond   <= pass;
            br_link   <= instr[24];
            br_offset <= instr[23:0];
        end else if (accept) begin
            alu_instr <= instr;
            alu_cond  <= pass;
        end else if (state == BR_RUN && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  flags_nzcv;
    logic        flush;
    logic        br_en, br_cond, br_link;
    logic [23:0] br_offset;
    logic        alu_valid;
    logic [31:0] alu_instr;
    logic        alu_cond;
    logic        alu_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .flags_nzcv  (flags_nzcv),
        .flush       (flush),
        .br_en       (br_en),
        .br_cond     (br_cond),
        .br_link     (br_link),
        .br_offset   (br_offset),
        .alu_valid   (alu_valid),
        .alu_instr   (alu_instr),
        .alu_cond    (alu_cond),
        .alu_ready   (alu_ready),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic br(input logic [31:0] ins, input logic [3:0] f, input int hold,
                      input logic c, input logic l, input logic [23:0] off, input logic fl);
        int n;
        @(negedge clk);
        chk("br_rdy", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = ins;
        flags_nzcv  = f;
        flush       = fl;
        @(negedge clk);
        instr_valid = 1'b0;
        flags_nzcv  = ~f;
        chk("br_lat", br_en, 1);
        chk("br_cond", br_cond, c);
        chk("br_link", br_link, l);
        chk("br_off", br_offset, off);
        n = 0;
        while (br_en && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("br_hold", n, hold);
        chk("gap_busy", busy, 1);
        chk("gap_rdy", instr_ready, 0);
        @(negedge clk);
        chk("br_idle_rdy", instr_ready, 1);
        chk("br_idle_busy", busy, 0);
        flush = 1'b0;
    endtask

    task automatic alu(input logic [31:0] ins, input logic [3:0] f, input logic c, input int waits);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        flags_nzcv  = f;
        @(negedge clk);
        instr_valid = 1'b0;
        flags_nzcv  = ~f;
        chk("alu_valid", alu_valid, 1);
        chk("alu_cond", alu_cond, c);
        chk("alu_instr", alu_instr, ins);
        chk("alu_no_br", br_en, 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("alu_wait", alu_valid, 1);
        end
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        chk("alu_done", alu_valid, 0);
        chk("alu_rdy", instr_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        flags_nzcv  = '0;
        flush       = 1'b0;
        alu_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_br_en", br_en, 0);
        chk("rst_off", br_offset, 0);
        chk("rst_alu", {alu_valid, alu_cond, busy}, 0);
        chk("rst_rdy", instr_ready, 1);
        rst_n = 1'b1;

        br(32'hEA000002, 4'b0000, 5, 1'b1, 1'b0, 24'h000002, 1'b0);
        br(32'hEB000010, 4'b0000, 8, 1'b1, 1'b1, 24'h000010, 1'b0);
        br(32'h0BFFFFFE, 4'b0000, 5, 1'b0, 1'b1, 24'hFFFFFE, 1'b0);
        br(32'hFB000003, 4'b1111, 5, 1'b0, 1'b1, 24'h000003, 1'b0);
        br(32'hCB000004, 4'b0000, 8, 1'b1, 1'b1, 24'h000004, 1'b0);
        br(32'hDB000005, 4'b1000, 8, 1'b1, 1'b1, 24'h000005, 1'b0);
        br(32'h8B000006, 4'b0110, 5, 1'b0, 1'b1, 24'h000006, 1'b0);
        br(32'hAB000007, 4'b1001, 8, 1'b1, 1'b1, 24'h000007, 1'b0);
        br(32'h3B000008, 4'b0000, 8, 1'b1, 1'b1, 24'h000008, 1'b0);
        br(32'hEB000010, 4'b0000, 8, 1'b1, 1'b1, 24'h000010, 1'b1);

        alu(32'hB0810002, 4'b1000, 1'b1, 3);
        alu(32'h10810002, 4'b0100, 1'b0, 0);

        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'hE0810002;
        flags_nzcv  = 4'b0000;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("fl_valid", alu_valid, 1);
        flush     = 1'b1;
        alu_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        alu_ready = 1'b0;
        chk("fl_drop", alu_valid, 0);
        chk("fl_idle", busy, 0);

        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'hEB000010;
        flags_nzcv  = 4'b0000;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ar_pre_link", br_link, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_br_en", br_en, 0);
        chk("ar_fields", {br_cond, br_link, br_offset}, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        br(32'hEA000000, 4'b0000, 5, 1'b1, 1'b0, 24'h000000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter BR_HOLD_SHORT, default 5, SHALL set the br_en hold cycles for a branch with condition false or L=0.
REQ-002 Parameter BR_HOLD_LINK, default 8, SHALL set the br_en hold cycles for a branch with condition true and L=1.
REQ-003 clk  input  1  SHALL be the single rising-edge clock.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 instr_valid  input  1  SHALL mark the fetched instruction as valid.
REQ-006 instr  input  32  SHALL carry the ARM instruction word.
REQ-007 instr_ready  output  1  SHALL indicate the block accepts instr this cycle.
REQ-008 flags_nzcv  input  4  SHALL carry CPSR flags {N,Z,C,V}.
REQ-009 flush  input  1  SHALL be a synchronous abort of a pending ALU issue.
REQ-010 br_en, br_cond, br_link  output  1 each  SHALL drive the branch unit's enable, condition-pass and link inputs.
REQ-011 br_offset  output  24  SHALL drive the branch unit's signed word offset.
REQ-012 alu_valid  output  1, alu_instr  output  32, alu_cond  output  1  SHALL present a non-branch instruction and its condition-pass result.
REQ-013 alu_ready  input  1  SHALL accept the ALU issue.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 Branch class SHALL be instr[27:25]==3'b101; link = instr[24]; offset = instr[23:0].
REQ-016 Condition SHALL be instr[31:28] evaluated against flags_nzcv sampled at the acceptance edge: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 4'b1111 0.
REQ-017 States SHALL be IDLE, BR_RUN, BR_GAP, ALU_WAIT; instr_ready SHALL be 1 only in IDLE (combinational from state).
REQ-018 IDLE with instr_valid=1: branch -> BR_RUN; non-branch -> ALU_WAIT; fields, cond and link latched at that edge.
REQ-019 BR_RUN: br_en=1 with br_cond, br_link, br_offset stable for exactly BR_HOLD_LINK cycles if cond&link, else BR_HOLD_SHORT cycles, counted by a 4-bit down-counter; then -> BR_GAP.
REQ-020 A branch with condition false SHALL still be issued (br_cond=0) so the branch unit advances PC by 4.
REQ-021 br_link SHALL be driven as latched L regardless of cond; hold length alone depends on cond&link.
REQ-022 BR_GAP: br_en=0 for exactly one cycle, then -> IDLE.
REQ-023 ALU_WAIT: alu_valid=1 with alu_instr, alu_cond stable until alu_valid&alu_ready at an edge, then -> IDLE.
REQ-024 flush=1 in ALU_WAIT SHALL drop alu_valid and -> IDLE at that edge, taking precedence over a simultaneous alu_ready; flush SHALL be ignored in IDLE, BR_RUN and BR_GAP (branch ops are not abortable).
REQ-025 Issue latency: br_en or alu_valid SHALL rise in the cycle after acceptance; minimum back-to-back branch spacing SHALL be hold+2 cycles.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, br_en=0, br_cond=0, br_link=0, br_offset=0, alu_valid=0, alu_instr=0, alu_cond=0, busy=0.
REQ-027 Reset mid-BR_RUN SHALL drop br_en asynchronously; the branch unit is reset by the same rst_n.

Structure
REQ-028 Condition-code constants (EQ..NV) and the state encoding SHALL live in shared package arm7_pkg.
REQ-029 The REQ-016 table SHALL be a combinational sub-module cond_eval (inputs cond[3:0], nzcv[3:0]; output pass).

Verification
REQ-030 instr=0xEA000002 (BAL, L=0), nzcv=0 -> br_en high 5 cycles, br_cond=1, br_link=0, br_offset=0x000002, then 1 gap cycle, instr_ready=1.
REQ-031 instr=0xEB000010 (BLAL) -> br_en high 8 cycles, br_link=1, br_offset=0x000010.
REQ-032 instr=0x0BFFFFFE (BLEQ) with Z=0 -> br_cond=0, br_link=1, br_en high 5 cycles.
REQ-033 instr=0xB0810002 (ADDLT), N=1,V=0 -> alu_valid=1, alu_cond=1; alu_ready held low 3 cycles, then 1 -> IDLE next cycle, instr_ready=1.
REQ-034 ALU_WAIT with flush=1 and alu_ready=1 same cycle -> alu_valid=0 next cycle, no handshake counted; flush during BR_RUN -> br_en duration unchanged.
REQ-035 rst_n asserted at BR_RUN cycle 3 -> all outputs zero immediately; after release, instr 0xEA000000 issues normally.
